iter_multiplier: RTL and testbench
==================================

# iter_multiplier

Iterative 32×32→32 multiply/multiply-accumulate unit for the processor's MUL/MLA instructions. It sits on the register-file read side: operands come from the three read-data ports. It returns its product to the write port together with the destination address and a write-enable pulse. While the unit works, it holds the rest of the core through a stall output, so the program counter (r15) does not advance until the result is written.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `AW`, 4: register address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue request, sampled on `clk` only in IDLE.
- `accumulate`  in  1  1 = MLA (add `op_c`), 0 = MUL; sampled with `start`.
- `op_a`  in  WIDTH  multiplicand (rD1).
- `op_b`  in  WIDTH  multiplier (rD2).
- `op_c`  in  WIDTH  accumulate operand (rD3).
- `dest`  in  AW  destination register; sampled with `start`.
- `stall`  out  1  holds PC/fetch. Combinational: `(state==IDLE && start) || state==RUN`.
- `busy`  out  1  registered; 1 in RUN and DONE.
- `wEn`  out  1  register-file write enable, 1-cycle pulse in DONE.
- `wA`  out  AW  write address, valid when `wEn`.
- `wD`  out  WIDTH  product, valid when `wEn`.
- `flag_n`, `flag_z`  out  1 each  `wD[31]` and `wD==0`, valid when `wEn`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`. In the same edge, latch `mcand=op_a`, `mplier=op_b`, `prod = accumulate ? op_c : 0`, `wA=dest`, `cnt=0`.
- RUN, each cycle:
  - If `mplier[0]`, then `prod += mcand` (mod 2^WIDTH).
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - After the iteration with `cnt==WIDTH-1`, go to DONE.
- DONE: `wEn=1`, `wD=prod`, flags driven. Next edge → IDLE unconditionally.
- `start` in RUN or DONE is ignored; the issuer must not present a new request. `stall` already covers the RUN cycles.
- Only the low WIDTH bits are kept. Signed and unsigned results are identical, and no overflow is reported.
- Operand inputs are don't-care outside the issue cycle. The register file may change them freely.
- `op_c` is don't-care when `accumulate=0`.

## Timing
- Start accepted at edge T. RUN occupies cycles T+1..T+32. DONE is cycle T+33, where `wEn=1` and the regfile writes at edge T+34. IDLE from T+34.
- Total latency is a fixed 33 cycles, independent of operand values. There is no early termination.
- `stall` is 1 from the issue cycle (before T) through the last RUN cycle. It is 0 in DONE, so the PC advances at the same edge the result is written.
- Back-to-back use: the earliest next `start` is sampled at edge T+34.
- Reset (async, any time, including mid-RUN or in DONE):
  - State → IDLE, all internal registers → 0.
  - `wEn`, `busy`, `stall` (absent `start`), `wA`, `wD`, `flag_n`, `flag_z` all read 0.
  - No write is issued for an aborted operation.
- `start` held high through reset release is accepted on the first edge after deassertion.

## Structure
- Shared processor header/package holds:
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - `WORD_W=32`, `REG_AW=4`.
  - Register index constant `PC_IDX=15`, reused by the register file and control.
- Single module; no sub-module needed. Datapath (adder, shifters, counter) and FSM live in one file. The counter is $clog2(WIDTH) bits.
- `wD` comes straight from the `prod` register. Flags are combinational from `prod`, gated by DONE.

## Test plan
- MUL 6×7, `dest=3`: stall high 33 cycles from issue; `wEn` single pulse at T+33, `wA=3`, `wD=42`, `flag_n=0`, `flag_z=0`.
- MLA `op_a=0xFFFFFFFF`, `op_b=2`, `op_c=5`, `accumulate=1` → `wD=0x00000003` (wraps), `flag_n=0`.
- MUL `0x80000000`×1 → `wD=0x80000000`, `flag_n=1`. MUL 0×`0x12345678` → `wD=0`, `flag_z=1`, still exactly 33-cycle latency.
- `start` pulsed at T+10 during RUN, with operands changed at T+1: ignored; result unaffected; only one `wEn` pulse.
- Assert `reset` at T+20: outputs 0 immediately (asynchronous); no `wEn` ever for that operation. A new MUL 3×3 after release → `wD=9` at its own T'+33.
- Back-to-back: second `start` at T+34 (`dest=4`, 2×5) → two `wEn` pulses at T+33 and T+67, `wD` 42 then 10.

Source files
------------

// File: rtl/iter_multiplier_pkg.sv
// Shared processor package: FSM encodings, word/register widths and the
// program-counter register index used by the register file and control.
package iter_multiplier_pkg;

    // Datapath word width and register-file address width of the core.
    localparam int WORD_W = 32;
    localparam int REG_AW = 4;

    // r15 is the program counter; the register file and control both key off it.
    localparam int PC_IDX = 15;

    // Multiplier FSM state type and encodings.
    typedef logic [1:0] mul_state_t;

    localparam mul_state_t ST_IDLE = 2'd0;
    localparam mul_state_t ST_RUN  = 2'd1;
    localparam mul_state_t ST_DONE = 2'd2;

endpackage : iter_multiplier_pkg

// File: rtl/iter_multiplier_if.sv
// Issue/write-back bundle between the register-file read side, the
// multiplier and the register-file write port.
interface iter_multiplier_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);

    // Issue side (driven by control / register-file read ports).
    logic             start;
    logic             accumulate;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic [AW-1:0]    dest;

    // Result / status side (driven by the multiplier).
    logic             stall;
    logic             busy;
    logic             wEn;
    logic [AW-1:0]    wA;
    logic [WIDTH-1:0] wD;
    logic             flag_n;
    logic             flag_z;

    // Issuer: presents requests, consumes the write-back and stall.
    modport master (
        output start, accumulate, op_a, op_b, op_c, dest,
        input  stall, busy, wEn, wA, wD, flag_n, flag_z
    );

    // Multiplier: accepts requests, produces the write-back and stall.
    modport slave (
        input  start, accumulate, op_a, op_b, op_c, dest,
        output stall, busy, wEn, wA, wD, flag_n, flag_z
    );

endinterface : iter_multiplier_if

// File: rtl/iter_multiplier.sv
// Iterative shift-and-add MUL/MLA unit. One multiplier bit per cycle, fixed
// WIDTH iterations, then a single write-back cycle to the register file.
module iter_multiplier
    import iter_multiplier_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int AW    = REG_AW
) (
    input  logic             clk,
    input  logic             reset,
    iter_multiplier_if.slave bus
);

    // Iteration counter just wide enough to count WIDTH iterations.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mul_state_t       state_r;
    mul_state_t       nextState_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] prod_r;
    logic [WIDTH-1:0] prodNext_s;
    logic [CW-1:0]    cnt_r;
    logic [AW-1:0]    wA_r;
    logic             wEn_r;
    logic             busy_r;
    logic             isDone_s;

    // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    nextState_s = ST_RUN;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    nextState_s = ST_DONE;
                end else begin
                    nextState_s = ST_RUN;
                end
            end
            ST_DONE: begin
                nextState_s = ST_IDLE;
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // Conditional add of the shifted multiplicand for the current multiplier bit.
    always_comb begin
        prodNext_s = prod_r;
        if (mplier_r[0]) begin
            prodNext_s = prod_r + mcand_r;
        end else begin
            prodNext_s = prod_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Datapath: latch operands on issue, then shift/add once per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            wA_r     <= {AW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand_r  <= bus.op_a;
                        mplier_r <= bus.op_b;
                        prod_r   <= bus.accumulate ? bus.op_c : {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        wA_r     <= bus.dest;
                    end
                end
                ST_RUN: begin
                    prod_r   <= prodNext_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                end
                default: begin
                    // DONE and unused encodings hold the result for write-back.
                    prod_r <= prod_r;
                end
            endcase
        end
    end

    // Registered status: busy covers RUN and DONE, wEn is the one-cycle DONE pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            wEn_r  <= 1'b0;
        end else begin
            busy_r <= (nextState_s == ST_RUN) || (nextState_s == ST_DONE);
            wEn_r  <= (nextState_s == ST_DONE);
        end
    end

    assign isDone_s = (state_r == ST_DONE);

    // Stall covers the issue cycle and every RUN cycle; it drops in DONE so
    // the PC advances on the same edge the result is written.
    assign bus.stall  = ((state_r == ST_IDLE) && bus.start) || (state_r == ST_RUN);
    assign bus.busy   = busy_r;
    assign bus.wEn    = wEn_r;
    assign bus.wA     = wA_r;
    assign bus.wD     = prod_r;
    assign bus.flag_n = isDone_s & prod_r[WIDTH-1];
    assign bus.flag_z = isDone_s & (prod_r == {WIDTH{1'b0}});

endmodule : iter_multiplier

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier: scoreboard of expected write-backs,
// per-scenario tasks checking latency, stall/busy timing, reset and results.
module tb_iter_multiplier;
    import iter_multiplier_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    iter_multiplier_if #(.WIDTH(32), .AW(4)) bus ();

    iter_multiplier #(.WIDTH(32), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
        logic        n;
        logic        z;
    } res_t;

    res_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference result: low 32 bits of a*b (+c for MLA), flags from the result.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input logic acc,
                                   input logic [3:0] dst);
        res_t r;
        logic [31:0] d;
        d = a * b;
        if (acc) d = d + c;
        r.a = dst;
        r.d = d;
        r.n = d[31];
        r.z = (d == 32'd0);
        return r;
    endfunction

    // Present one request for one cycle (cycle 0), then scramble operands.
    // Returns at the negedge of cycle 1.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic acc, input logic [3:0] dst, output logic stall0);
        @(negedge clk);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.op_c       = c;
        bus.accumulate = acc;
        bus.dest       = dst;
        bus.start      = 1'b1;
        sbQ.push_back(model(a, b, c, acc, dst));
        #1 stall0 = bus.stall;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
        bus.op_c       = $urandom;
        bus.accumulate = 1'($urandom_range(1, 0));
        bus.dest       = 4'($urandom_range(15, 0));
    endtask

    // Step negedges until wEn is seen (bounded); counts cycles with stall high.
    task automatic wait_wen(input int fromCyc, output int cyc, output int stallCnt);
        cyc = fromCyc;
        stallCnt = 0;
        while (bus.wEn !== 1'b1 && cyc < 200) begin
            if (bus.stall === 1'b1) stallCnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    // Count wEn pulses over n cycles.
    task automatic count_wen(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.wEn === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset();
        logic [41:0] outs;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.accumulate = 1'b0;
        bus.op_a       = 32'd0;
        bus.op_b       = 32'd0;
        bus.op_c       = 32'd0;
        bus.dest       = 4'd0;
        repeat (3) @(negedge clk);
        outs = {bus.wEn, bus.busy, bus.stall, bus.flag_n, bus.flag_z, bus.wA, bus.wD};
        checks++;
        if (outs !== 42'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", outs);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        outs = {bus.wEn, bus.busy, bus.stall, bus.flag_n, bus.flag_z, bus.wA, bus.wD};
        checks++;
        if (outs !== 42'd0) begin
            errors++;
            $display("FAIL idle_after_release got %h expected 0", outs);
        end
    endtask

    task automatic test_mul_basic();
        logic s0;
        int   cyc, sc;
        res_t exp, got;
        issue(32'd6, 32'd7, 32'd0, 1'b0, 4'd3, s0);
        checks++;
        if (bus.busy !== 1'b1 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL basic_run_status got busy=%b stall=%b expected 1 1", bus.busy, bus.stall);
        end
        wait_wen(1, cyc, sc);
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL basic_latency got %0d expected 33", cyc);
        end
        checks++;
        if (int'(s0) + sc !== 33) begin
            errors++;
            $display("FAIL basic_stall_cycles got %0d expected 33", int'(s0) + sc);
        end
        checks++;
        if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_done_status got stall=%b busy=%b expected 0 1", bus.stall, bus.busy);
        end
        got = {bus.wA, bus.wD, bus.flag_n, bus.flag_z};
        exp = (sbQ.size() > 0) ? sbQ.pop_front() : res_t'(0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_result got %h expected %h", got, exp);
        end
        @(negedge clk);
        checks++;
        if (bus.wEn !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_pulse got wEn=%b busy=%b expected 0 0", bus.wEn, bus.busy);
        end
    endtask

    task automatic test_table();
        logic [31:0] a, b, c;
        logic        acc, s0;
        logic [3:0]  dst;
        int          cyc, sc;
        res_t        exp, got;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin a = 32'hFFFF_FFFF; b = 32'd2; c = 32'd5; acc = 1'b1; dst = 4'd1; end
                1: begin a = 32'h8000_0000; b = 32'd1; c = 32'd9; acc = 1'b0; dst = 4'd2; end
                2: begin a = 32'd0; b = 32'h1234_5678; c = 32'hDEAD_BEEF; acc = 1'b0; dst = 4'd14; end
                3: begin a = 32'd7; b = 32'hFFFF_FFFF; c = 32'd100; acc = 1'b1; dst = 4'd15; end
                default: begin
                    a = $urandom; b = $urandom; c = $urandom;
                    acc = 1'($urandom_range(1, 0)); dst = 4'($urandom_range(15, 0));
                end
            endcase
            issue(a, b, c, acc, dst, s0);
            wait_wen(1, cyc, sc);
            checks++;
            if (cyc !== 33 || int'(s0) + sc !== 33) begin
                errors++;
                $display("FAIL table%0d_timing got latency=%0d stall=%0d expected 33 33",
                         i, cyc, int'(s0) + sc);
            end
            got = {bus.wA, bus.wD, bus.flag_n, bus.flag_z};
            exp = (sbQ.size() > 0) ? sbQ.pop_front() : res_t'(0);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL table%0d_result got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic s0;
        int   cyc, sc, extra;
        res_t exp, got;
        issue(32'd11, 32'd13, 32'd0, 1'b0, 4'd5, s0);
        repeat (9) @(negedge clk);
        bus.start      = 1'b1;
        bus.op_a       = 32'd99;
        bus.op_b       = 32'd98;
        bus.op_c       = 32'd97;
        bus.accumulate = 1'b1;
        bus.dest       = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_wen(11, cyc, sc);
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL ignore_latency got %0d expected 33", cyc);
        end
        got = {bus.wA, bus.wD, bus.flag_n, bus.flag_z};
        exp = (sbQ.size() > 0) ? sbQ.pop_front() : res_t'(0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL ignore_result got %h expected %h", got, exp);
        end
        count_wen(40, extra);
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_extra_wen got %0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run();
        logic        s0;
        logic [41:0] outs;
        int          cyc, sc, during;
        res_t        exp, got;
        issue(32'h1234, 32'h10, 32'd0, 1'b0, 4'd7, s0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        outs = {bus.wEn, bus.busy, bus.stall, bus.flag_n, bus.flag_z, bus.wA, bus.wD};
        checks++;
        if (outs !== 42'd0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got %h expected 0", outs);
        end
        sbQ.delete();
        bus.op_a       = 32'd3;
        bus.op_b       = 32'd3;
        bus.op_c       = 32'd77;
        bus.accumulate = 1'b0;
        bus.dest       = 4'd9;
        bus.start      = 1'b1;
        sbQ.push_back(model(32'd3, 32'd3, 32'd77, 1'b0, 4'd9));
        count_wen(2, during);
        reset = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        wait_wen(1, cyc, sc);
        checks++;
        if (during !== 0 || cyc !== 33) begin
            errors++;
            $display("FAIL midrun_restart got wen_in_reset=%0d latency=%0d expected 0 33", during, cyc);
        end
        got = {bus.wA, bus.wD, bus.flag_n, bus.flag_z};
        exp = (sbQ.size() > 0) ? sbQ.pop_front() : res_t'(0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL midrun_result got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic s0;
        int   cyc1, cyc2, sc;
        res_t exp, got;
        issue(32'd6, 32'd7, 32'd0, 1'b0, 4'd3, s0);
        wait_wen(1, cyc1, sc);
        got = {bus.wA, bus.wD, bus.flag_n, bus.flag_z};
        exp = (sbQ.size() > 0) ? sbQ.pop_front() : res_t'(0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_first_result got %h expected %h", got, exp);
        end
        issue(32'd2, 32'd5, 32'd0, 1'b0, 4'd4, s0);
        wait_wen(1, cyc2, sc);
        checks++;
        if (s0 !== 1'b1 || cyc1 + 1 + cyc2 !== 67) begin
            errors++;
            $display("FAIL b2b_timing got stall0=%b second_wen_at=%0d expected 1 67", s0, cyc1 + 1 + cyc2);
        end
        got = {bus.wA, bus.wD, bus.flag_n, bus.flag_z};
        exp = (sbQ.size() > 0) ? sbQ.pop_front() : res_t'(0);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL b2b_second_result got %h expected %h", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_table();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_iter_multiplier
